aes_axis_out: RTL and testbench
===============================

# aes_axis_out

Transmit-side stream formatter for the AES datapath. It drains 128-bit result blocks from the output FIFO written by the AES controller and serializes each block into four 32-bit AXI-Stream master beats toward the DMA. It asserts `m_axis_tlast` on the final beat of a packet, using the controller's `processing_done` as the end-of-packet indication. It also reports per-packet block count and a completion pulse.

## Interface
- `FIFO_DATA_WIDTH`, 128, output FIFO word width; fixed at one AES block.
- `C_M_AXIS_TDATA_WIDTH`, 32, AXI-Stream beat width; `FIFO_DATA_WIDTH` must be exactly 4× this.
- `CNT_WIDTH`, 16, width of `blocks_sent`.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low reset.
- `processing_done`  in  1  level from the controller; all blocks of the current packet are written to the output FIFO.
- `out_fifo_data`  in  FIFO_DATA_WIDTH  FIFO head word, first-word-fall-through.
- `out_fifo_empty`  in  1  FIFO empty flag; valid the cycle after any write handshake.
- `out_fifo_read_tvalid`  in  1  FIFO head valid.
- `out_fifo_read_tready`  out  1  pop request.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tdata`  out  C_M_AXIS_TDATA_WIDTH  beat data.
- `m_axis_tstrb`  out  4  byte strobes; always 4'hF when valid, 4'h0 otherwise.
- `m_axis_tlast`  out  1  last beat of packet.
- `m_axis_tready`  in  1  downstream accept.
- `tx_done`  out  1  one-cycle pulse after the tlast handshake.
- `blocks_sent`  out  CNT_WIDTH  blocks fully transmitted in the current or most recent packet.

## Operation
- Register set:
  - `blk_reg` (128 b)
  - 2-bit `beat_idx`
  - `done_seen` flag, latched from `processing_done`
  - `blocks_sent` counter
- States:
  - **IDLE**: `out_fifo_read_tready`=1. On a FIFO handshake (`tready && tvalid`):
    - capture `out_fifo_data` into `blk_reg`; `beat_idx`←0
    - if this is the first block after `tx_done` or reset, `blocks_sent`←0
    - go to **SEND**.
  - **SEND**: `m_axis_tvalid`=1, `tlast`=0, beats 0..2. Each beat handshake increments `beat_idx`. The handshake at `beat_idx`=2 goes to **DECIDE**.
  - **DECIDE** (beat 3 held, `tvalid`=0):
    - if `out_fifo_empty`=0 → **SEND_MID**.
    - else if `done_seen`=1 → **SEND_LAST**.
    - else stay; wait for either condition.
    - If both hold in the same cycle, non-empty wins (**SEND_MID**).
  - **SEND_MID**: beat 3 with `tlast`=0. On handshake: `blocks_sent`++ and go to **IDLE**.
  - **SEND_LAST**: beat 3 with `tlast`=1. On handshake:
    - `blocks_sent`++, `done_seen`←0
    - `tx_done` pulses the next cycle
    - go to **IDLE**.
- Beat order is MSB first: beat k carries `blk_reg[127-32k -: 32]`.
- `done_seen` sets on any cycle with `processing_done`=1 while not in **SEND_LAST**. It is cleared only by the tlast handshake or reset.
- A `processing_done` with no block ever loaded (empty packet) sends nothing. `done_seen` stays set until the next block's tlast.
- `blocks_sent` saturates at all-ones; no wrap.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state **IDLE**
  - `out_fifo_read_tready`=0 during reset, 1 from the first cycle after release
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tstrb`=0
  - `tx_done`=0, `blocks_sent`=0, `done_seen`=0
- Reset mid-packet discards the partial block. `tvalid` drops asynchronously.
- All outputs are registered.
- FIFO pop to first beat valid: 1 cycle.
- Steady-state throughput with `tready`=1 is 6 cycles/block: 1 load, 3 SEND, 1 DECIDE, 1 SEND_MID/LAST.
- AXI rules:
  - once `tvalid`=1, `tdata`/`tlast`/`tstrb` hold until the handshake
  - `tvalid` never depends combinationally on `tready`.
- `out_fifo_read_tready` is 0 in every state except **IDLE**; at most one block is buffered.

## Configuration
- `AES_AXIS_OUT_BYTESWAP_EN`:
  - Defined: each beat is byte-reversed before output, i.e. `tdata[7:0]`←word[31:24], and so on.
  - Undefined: the word is passed unchanged.
  - Swapping is applied at the register input, so latency is identical either way.

## Test plan
- Single block 128'h00112233_44556677_8899AABB_CCDDEEFF, FIFO then empty, `processing_done`=1, `tready`=1:
  - beats 00112233, 44556677, 8899AABB, CCDDEEFF
  - tlast only on the 4th beat
  - `tx_done` pulse; `blocks_sent`=1.
- Three back-to-back blocks, `processing_done` raised after the third write:
  - 12 beats; tlast only on beat 12
  - `blocks_sent`=3.
- FIFO empty at DECIDE with `processing_done`=0 for 20 cycles, then block 2 arrives:
  - beat 3 of block 1 stays invalid for those cycles, then sent with tlast=0.
- `tready` toggling 1-0-1-0 during beats:
  - `tdata`/`tlast` stable while stalled
  - no beat dropped or duplicated.
- Reset asserted while `beat_idx`=1:
  - `tvalid`=0 immediately; `blocks_sent`=0
  - next packet starts at beat 0 of a freshly popped block.
- With `AES_AXIS_OUT_BYTESWAP_EN`, block 128'h00112233_...: first beat 33221100.

Source files
------------

// File: rtl/aes_axis_out.sv
// aes_axis_out -- transmit-side stream formatter for the AES datapath.
//
// Pops 128-bit result blocks from a first-word-fall-through output FIFO and
// serializes each into four 32-bit AXI-Stream beats, MSB word first. The
// final beat of a packet carries tlast; the end of a packet is signalled by
// the controller's processing_done level, which is latched into done_seen.
// Beat 3 of every block is held back (DECIDE) until either another block is
// waiting (beat 3 goes out with tlast=0) or the packet is known to be over
// (beat 3 goes out with tlast=1).
//
// Optional build macro:
//   AES_AXIS_OUT_BYTESWAP_EN  byte-reverse every beat before it is registered
//
// Ports:
//   clk                   single clock
//   reset                 asynchronous, active-low reset
//   processing_done       controller: all blocks of the packet are in the FIFO
//   out_fifo_data         FIFO head word (FWFT)
//   out_fifo_empty        FIFO empty flag
//   out_fifo_read_tvalid  FIFO head valid
//   out_fifo_read_tready  FIFO pop request (only in IDLE)
//   m_axis_tvalid/tdata/tstrb/tlast/tready  AXI-Stream master
//   tx_done               one-cycle pulse after the tlast handshake
//   blocks_sent           blocks sent in the current/most recent packet

module aes_axis_out #(
  parameter int FIFO_DATA_WIDTH      = 128,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            processing_done,
  input  logic [FIFO_DATA_WIDTH-1:0]      out_fifo_data,
  input  logic                            out_fifo_empty,
  input  logic                            out_fifo_read_tvalid,
  output logic                            out_fifo_read_tready,
  output logic                            m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]                      m_axis_tstrb,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            tx_done,
  output logic [CNT_WIDTH-1:0]            blocks_sent
);

  localparam int W = C_M_AXIS_TDATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    DECIDE,
    SEND_MID,
    SEND_LAST
  } state_t;

  state_t                     state, state_next;
  logic [FIFO_DATA_WIDTH-1:0] blk_reg;
  logic [1:0]                 beat_idx;
  logic                       done_seen;
  logic                       first_blk;
  logic                       fifo_hs;
  logic                       axis_hs;
  logic                       beat_vld_next;

  function automatic logic [W-1:0] fmt_beat(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef AES_AXIS_OUT_BYTESWAP_EN
    for (int i = 0; i < W / 8; i++) begin
      r[8*i +: 8] = w[W-8-8*i +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // Beat k is the k-th W-bit word counted from the MSB end of the block.
  function automatic logic [W-1:0] beat_of(input logic [FIFO_DATA_WIDTH-1:0] blk,
                                           input logic [1:0] idx);
    logic [FIFO_DATA_WIDTH-1:0] s;
    s = blk << (W * int'(idx));
    return s[FIFO_DATA_WIDTH-1 -: W];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign fifo_hs = out_fifo_read_tready && out_fifo_read_tvalid;
  assign axis_hs = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (fifo_hs) state_next = SEND;
      SEND:      if (axis_hs && beat_idx == 2'd2) state_next = DECIDE;
      // A waiting block beats the end-of-packet indication: the packet
      // cannot end while more of its blocks are still queued.
      DECIDE: begin
        if (!out_fifo_empty)  state_next = SEND_MID;
        else if (done_seen)   state_next = SEND_LAST;
      end
      SEND_MID:  if (axis_hs) state_next = IDLE;
      SEND_LAST: if (axis_hs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign beat_vld_next = (state_next == SEND) || (state_next == SEND_MID) ||
                         (state_next == SEND_LAST);

  // Control and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      beat_idx             <= 2'd0;
      done_seen            <= 1'b0;
      first_blk            <= 1'b1;
      blocks_sent          <= '0;
      tx_done              <= 1'b0;
      out_fifo_read_tready <= 1'b0;
      m_axis_tvalid        <= 1'b0;
      m_axis_tlast         <= 1'b0;
      m_axis_tstrb         <= 4'h0;
      m_axis_tdata         <= '0;
    end else begin
      state                <= state_next;
      out_fifo_read_tready <= (state_next == IDLE);
      m_axis_tvalid        <= beat_vld_next;
      m_axis_tstrb         <= {4{beat_vld_next}};
      m_axis_tlast         <= (state_next == SEND_LAST);
      tx_done              <= (state == SEND_LAST) && axis_hs;

      if (state == SEND_LAST && axis_hs) begin
        done_seen <= 1'b0;
      end else if (processing_done && state != SEND_LAST) begin
        done_seen <= 1'b1;
      end

      case (state)
        IDLE: if (fifo_hs) begin
          beat_idx     <= 2'd0;
          m_axis_tdata <= fmt_beat(out_fifo_data[FIFO_DATA_WIDTH-1 -: W]);
          first_blk    <= 1'b0;
          if (first_blk) blocks_sent <= '0;
        end
        // The handshake of beat 2 also loads beat 3, which DECIDE holds.
        SEND: if (axis_hs) begin
          beat_idx     <= beat_idx + 2'd1;
          m_axis_tdata <= fmt_beat(beat_of(blk_reg, beat_idx + 2'd1));
        end
        SEND_MID: if (axis_hs) begin
          blocks_sent <= sat_inc(blocks_sent);
        end
        SEND_LAST: if (axis_hs) begin
          blocks_sent <= sat_inc(blocks_sent);
          first_blk   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Block buffer
  always_ff @(posedge clk) begin
    if (state == IDLE && fifo_hs) blk_reg <= out_fifo_data;
  end

endmodule

// File: tb/tb_aes_axis_out.sv
// tb_aes_axis_out -- directed bench for aes_axis_out. A queue models the
// FWFT output FIFO; a monitor logs every accepted beat and tx_done pulse,
// and checks that stalled beats hold their data.
module tb_aes_axis_out;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         processing_done = 1'b0;
  logic [127:0] out_fifo_data;
  logic         out_fifo_empty;
  logic         out_fifo_read_tvalid;
  logic         out_fifo_read_tready;
  logic         m_axis_tvalid;
  logic [31:0]  m_axis_tdata;
  logic [3:0]   m_axis_tstrb;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic         tx_done;
  logic [15:0]  blocks_sent;

  int n_chk = 0;
  int n_err = 0;

  aes_axis_out dut (
    .clk                  (clk),
    .reset                (reset),
    .processing_done      (processing_done),
    .out_fifo_data        (out_fifo_data),
    .out_fifo_empty       (out_fifo_empty),
    .out_fifo_read_tvalid (out_fifo_read_tvalid),
    .out_fifo_read_tready (out_fifo_read_tready),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tstrb         (m_axis_tstrb),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tready        (m_axis_tready),
    .tx_done              (tx_done),
    .blocks_sent          (blocks_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes land in the queue at a negedge, flags follow at the
  // next posedge.
  logic [127:0] fq[$];
  initial begin
    out_fifo_data        = '0;
    out_fifo_empty       = 1'b1;
    out_fifo_read_tvalid = 1'b0;
  end
  always @(posedge clk) begin
    if (out_fifo_read_tready && out_fifo_read_tvalid && fq.size() > 0)
      void'(fq.pop_front());
    out_fifo_data        <= (fq.size() > 0) ? fq[0] : '0;
    out_fifo_empty       <= (fq.size() == 0);
    out_fifo_read_tvalid <= (fq.size() > 0);
  end

  // Monitor
  logic [31:0] bq_d[$];
  logic        bq_l[$];
  int          txd_cnt = 0;
  int          unstable = 0;
  logic        stall_p = 1'b0;
  logic [31:0] d_p = '0;
  logic        l_p = 1'b0;
  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      bq_d.push_back(m_axis_tdata);
      bq_l.push_back(m_axis_tlast);
    end
    if (tx_done) txd_cnt++;
    if (stall_p && (!m_axis_tvalid || m_axis_tdata != d_p || m_axis_tlast != l_p))
      unstable++;
    stall_p = m_axis_tvalid && !m_axis_tready;
    d_p     = m_axis_tdata;
    l_p     = m_axis_tlast;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input logic [127:0] blk, input int k);
    logic [31:0] w;
    w = blk[127-32*k -: 32];
`ifdef AES_AXIS_OUT_BYTESWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic push(input logic [127:0] blk);
    @(negedge clk);
    fq.push_back(blk);
  endtask

  task automatic pulse_done();
    @(negedge clk) processing_done = 1'b1;
    @(negedge clk) processing_done = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int maxc, input bit toggle);
    int t0;
    t0 = txd_cnt;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (txd_cnt > t0) break;
      if (toggle) m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    chk({tag, "_txdone_seen"}, 64'(txd_cnt > t0), 64'd1);
  endtask

  task automatic chk_pkt(input string tag, input int base, input logic [127:0] blks[4],
                         input int nb);
    chk({tag, "_nbeats"}, 64'(bq_d.size() - base), 64'(4 * nb));
    for (int k = 0; k < 4 * nb; k++) begin
      if (base + k < bq_d.size()) begin
        chk($sformatf("%s_data%0d", tag, k), 64'(bq_d[base+k]), 64'(exp_beat(blks[k/4], k % 4)));
        chk($sformatf("%s_last%0d", tag, k), 64'(bq_l[base+k]), 64'(k == 4 * nb - 1));
      end
    end
  endtask

  logic [127:0] blks[4];
  int base;
  int t1;
  int vcnt;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy",    64'(out_fifo_read_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast",  64'(m_axis_tlast), 64'd0);
    chk("rst_tdata",  64'(m_axis_tdata), 64'd0);
    chk("rst_tstrb",  64'(m_axis_tstrb), 64'd0);
    chk("rst_txdone", 64'(tx_done), 64'd0);
    chk("rst_cnt",    64'(blocks_sent), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 64'(out_fifo_read_tready), 64'd1);

    // Single block packet
    blks[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    base = bq_d.size();
    t1 = txd_cnt;
    push(blks[0]);
    pulse_done();
    wait_tx("single", 60, 1'b0);
    chk_pkt("single", base, blks, 1);
    chk("single_cnt", 64'(blocks_sent), 64'd1);
    repeat (3) @(negedge clk);
    chk("single_pulses", 64'(txd_cnt - t1), 64'd1);
    chk("idle_tstrb", 64'(m_axis_tstrb), 64'd0);

    // Three back-to-back blocks
    blks[0] = 128'h01010101_02020202_03030303_04040404;
    blks[1] = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    blks[2] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    base = bq_d.size();
    push(blks[0]);
    push(blks[1]);
    push(blks[2]);
    pulse_done();
    wait_tx("three", 100, 1'b0);
    chk_pkt("three", base, blks, 3);
    chk("three_cnt", 64'(blocks_sent), 64'd3);

    // FIFO runs dry at DECIDE without processing_done
    blks[0] = 128'h11111111_22222222_33333333_44444444;
    blks[1] = 128'h55555555_66666666_77777777_88888888;
    base = bq_d.size();
    push(blks[0]);
    for (int i = 0; i < 50 && (bq_d.size() - base) < 3; i++) @(negedge clk);
    chk("dry_three_beats", 64'(bq_d.size() - base), 64'd3);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) vcnt++;
    end
    chk("dry_hold_invalid", 64'(vcnt), 64'd0);
    chk("dry_hold_data", 64'(m_axis_tdata), 64'(exp_beat(blks[0], 3)));
    push(blks[1]);
    pulse_done();
    wait_tx("dry", 80, 1'b0);
    chk_pkt("dry", base, blks, 2);
    chk("dry_cnt", 64'(blocks_sent), 64'd2);

    // tready toggling
    blks[0] = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    base = bq_d.size();
    push(blks[0]);
    pulse_done();
    wait_tx("stall", 80, 1'b1);
    chk_pkt("stall", base, blks, 1);
    chk("stall_stable", 64'(unstable), 64'd0);
    chk("stall_cnt", 64'(blocks_sent), 64'd1);

    // Reset mid-block (beat_idx = 1)
    blks[0] = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    base = bq_d.size();
    push(blks[0]);
    for (int i = 0; i < 50 && (bq_d.size() - base) < 1; i++) @(negedge clk);
    chk("mid_one_beat", 64'(bq_d.size() - base), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_cnt",    64'(blocks_sent), 64'd0);
    chk("mid_rst_rdy",    64'(out_fifo_read_tready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    blks[0] = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
    base = bq_d.size();
    push(blks[0]);
    pulse_done();
    wait_tx("after_rst", 60, 1'b0);
    chk_pkt("after_rst", base, blks, 1);
    chk("after_rst_cnt", 64'(blocks_sent), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
